// File: rtl/serial_addsub8_pkg.sv
// Shared ALU definitions for the bit-serial adder/subtractor: FSM encoding,
// default operand width and the counter-width helper.
package serial_addsub8_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } alu_state_e;

    // Bits needed to count 0..w-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/add1b.sv
// One-bit full adder cell: the only arithmetic element of the serial datapath.
module add1b (
    input  logic ci,
    input  logic a,
    input  logic b,
    output logic r,
    output logic co
);

    logic w_p;

    assign w_p = a ^ b;
    assign r   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/serial_addsub8.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a single
// full-adder cell. Results are published only on entry to the DONE state.
module serial_addsub8
    import serial_addsub8_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             co,
    output logic             ov,
    output logic             z
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    alu_state_e r_state;
    alu_state_e w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_res;
    logic [CntW-1:0]  r_cnt;
    logic             r_carry;
    logic             r_co;
    logic             r_ov;
    logic             r_z;

    logic             w_load;
    logic             w_last;
    logic             w_bit;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum_next;

    add1b u_add1b (
        .ci (r_carry),
        .a  (r_a[0]),
        .b  (r_b[0]),
        .r  (w_bit),
        .co (w_cout)
    );

    assign w_last     = (r_cnt == LastCnt);
    assign w_sum_next = {w_bit, r_sum[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = StShift;
                end
            end
            StShift: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                done = 1'b1;
                // A start seen in DONE chains straight into the next operation.
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = StShift;
                end else begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_res   <= '0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
            r_z     <= 1'b0;
        end else if (w_load) begin
            // Subtract as a + ~b + 1: the inverted operand plus a preset carry.
            r_a     <= a;
            r_b     <= op ? ~b : b;
            r_carry <= op;
            r_cnt   <= '0;
        end else if (r_state == StShift) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= w_sum_next;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                // r_carry here is the carry into the MSB.
                r_res <= w_sum_next;
                r_co  <= w_cout;
                r_ov  <= r_carry ^ w_cout;
                r_z   <= ~|w_sum_next;
            end
        end
    end

    assign r  = r_res;
    assign co = r_co;
    assign ov = r_ov;
    assign z  = r_z;

endmodule

// File: tb/tb_serial_addsub8.sv
// Self-checking bench for serial_addsub8: directed vectors, multi-cycle corner
// sequences and randomized operations against an integer arithmetic model.
module tb_serial_addsub8;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    logic         z;

    int n_total;
    int n_pass;
    logic [W-1:0] prev_r;

    serial_addsub8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .r     (r),
        .co    (co),
        .ov    (ov),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference from signed/unsigned integer arithmetic, not from carry chains.
    task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] er, output logic eco, output logic eov,
                         output logic ez);
        int sx, sy, res, ux, uy;
        ux  = int'(x);
        uy  = int'(y);
        sx  = (ux >= 128) ? ux - 256 : ux;
        sy  = (uy >= 128) ? uy - 256 : uy;
        res = o ? sx - sy : sx + sy;
        eov = (res > 127) || (res < -128);
        eco = o ? (ux >= uy) : (ux + uy > 255);
        er  = W'(o ? ux - uy : ux + uy);
        ez  = (er == '0);
    endtask

    // Drives a request, then checks busy/done timing and the published result.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] er, input logic eco, input logic eov,
                          input logic ez, input int repulse);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 1'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            chk("r_held", 32'(r), 32'(prev_r));
            if (i == repulse) begin
                start = 1'b1;
                op    = 1'b0;
                a     = 8'hff;
                b     = 8'hff;
            end else if (i == repulse + 1) begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("done", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("r", 32'(r), 32'(er));
        chk("co", 32'(co), 32'(eco));
        chk("ov", 32'(ov), 32'(eov));
        chk("z", 32'(z), 32'(ez));
        prev_r = er;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t vecs[5];
        logic [W-1:0] er;
        logic eco, eov, ez;
        logic o;
        logic [W-1:0] x, y;

        n_total = 0;
        n_pass  = 0;
        prev_r  = '0;
        rst     = 1'b1;
        start   = 1'b1;
        op      = 1'b0;
        a       = 8'h55;
        b       = 8'h0f;

        vecs[0] = '{op: 1'b0, a: 8'h01, b: 8'h01, r: 8'h02, co: 1'b0, ov: 1'b0, z: 1'b0};
        vecs[1] = '{op: 1'b0, a: 8'hff, b: 8'h01, r: 8'h00, co: 1'b1, ov: 1'b0, z: 1'b1};
        vecs[2] = '{op: 1'b0, a: 8'h7f, b: 8'h01, r: 8'h80, co: 1'b0, ov: 1'b1, z: 1'b0};
        vecs[3] = '{op: 1'b1, a: 8'h05, b: 8'h07, r: 8'hfe, co: 1'b0, ov: 1'b0, z: 1'b0};
        vecs[4] = '{op: 1'b1, a: 8'h80, b: 8'h01, r: 8'h7f, co: 1'b1, ov: 1'b1, z: 1'b0};

        // Reset wins over a concurrently asserted start.
        gap(3);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_ov", 32'(ov), 32'd0);
        chk("rst_z", 32'(z), 32'd0);

        foreach (vecs[i]) begin
            gap(1);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].co, vecs[i].ov,
                   vecs[i].z, -10);
        end

        // Re-pulsed start during SHIFT is ignored.
        gap(1);
        run_op(1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, 3);
        @(negedge clk);
        chk("repulse_no_restart", 32'(busy), 32'd0);

        // Start held through DONE chains a second operation.
        gap(1);
        run_op(1'b0, 8'h10, 8'h05, 8'h15, 1'b0, 1'b0, 1'b0, -10);
        run_op(1'b1, 8'h03, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, -10);

        // Reset in the middle of SHIFT aborts with no done pulse.
        gap(1);
        start = 1'b1;
        op    = 1'b0;
        a     = 8'h44;
        b     = 8'h22;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_r", 32'(r), 32'd0);
        chk("abort_co", 32'(co), 32'd0);
        chk("abort_ov", 32'(ov), 32'd0);
        chk("abort_z", 32'(z), 32'd0);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        prev_r = '0;

        // Random operations, some chained back-to-back (gap 0).
        for (int k = 0; k < 40; k++) begin
            gap(int'($urandom_range(0, 2)));
            o = 1'($urandom);
            x = W'($urandom);
            y = W'($urandom);
            model(o, x, y, er, eco, eov, ez);
            run_op(o, x, y, er, eco, eov, ez, -10);
        end

        gap(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
